imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Pipelined, parametrised immediate-extension unit for the datapath's decode stage. It takes an IN_W-bit immediate plus a per-transaction mode and produces an OUT_W-bit operand: sign-extended, zero-extended, or sign-extended and shifted left by 2 for branch offsets. A valid/ready handshake on both sides with a 2-entry skid buffer lets decode stall without dropping immediates, while every handshake signal stays registered.

## Interface
- IN_W, 16, immediate input width; legal range 2..OUT_W-2.
- OUT_W, 32, extended output width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  unit can accept; registered.
- in_data  input  IN_W  raw immediate.
- in_mode  input  2  00 sign-ext, 01 zero-ext, 10 sign-ext then <<2, 11 see Configuration.
- out_valid  output  1  out_data valid; registered.
- out_ready  input  1  consumer accepts.
- out_data  output  OUT_W  extended result; registered.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- The extension is computed combinationally from in_data/in_mode and captured at input transfer.
  - Mode 00: {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}.
  - Mode 01: {(OUT_W-IN_W){1'b0}, in_data}.
  - Mode 10: {(OUT_W-IN_W-2){in_data[IN_W-1]}, in_data, 2'b00}. No bits are lost, because OUT_W >= IN_W+2.
- Storage consists of a main register (drives out_data) and a skid register. Occupancy states:
  - EMPTY: out_valid=0, in_ready=1.
    - Input transfer -> ONE; the result goes to main.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer in the same cycle -> ONE; main is loaded with the new result.
    - Output transfer only -> EMPTY.
    - Input transfer only -> TWO; the result goes to skid.
    - Neither -> ONE; main is held.
  - TWO: out_valid=1, in_ready=0.
    - Output transfer -> ONE; main is loaded from skid.
    - Otherwise hold.
- Ordering is strict FIFO. A result is never duplicated or dropped.
- in_valid while in_ready=0 is ignored; the producer must hold its data.
- Reset (asynchronous, any time, including mid-stall): state EMPTY, out_valid=0, out_data=0, in_ready=1, skid cleared. Any in-flight entries are discarded.

## Timing
- Latency is 1 cycle: an immediate accepted at edge N appears on out_data with out_valid=1 after edge N.
- Throughput is 1 per cycle while out_ready=1.
- in_ready falls the cycle after the skid register fills.
- in_ready rises the cycle after the skid entry drains.
- No combinational path exists from out_ready to in_ready, or from in_* to out_*.
- out_data is stable while out_valid=1 and out_ready=0.

## Configuration
- IMM_EXT_UPPER_EN defined: mode 11 is upper-immediate. The result is {in_data, (OUT_W-IN_W){1'b0}}, used for LUI-style operands.
- IMM_EXT_UPPER_EN undefined: mode 11 decodes exactly as mode 00 (sign-extend), and no upper-placement logic is synthesised.
- Handshake timing is identical in both builds.

## Test plan
- Reset, then IN_W=16/OUT_W=32, in_mode=00, in_data=16'h8001, out_ready=1 -> one cycle later out_valid=1, out_data=32'hFFFF8001. The same input with in_mode=01 -> 32'h00008001.
- in_mode=10 with in_data=16'hFFFF -> 32'hFFFFFFFC; with in_data=16'h4000 -> 32'h00010000.
- in_mode=11 with in_data=16'h1234:
  - With IMM_EXT_UPPER_EN -> 32'h12340000.
  - Without it -> 32'h00001234.
  - With in_data=16'h9000 and no macro -> 32'hFFFF9000.
- Hold out_ready=0 and stream 3 values (1, 2, 3) with in_valid=1:
  - Values 1 and 2 are accepted; in_ready=0 after the second accept, and value 3 is held by the producer.
  - Raise out_ready -> outputs appear in order 1, 2, 3 on consecutive cycles with no gaps or duplicates.
- Continuous in_valid=1/out_ready=1 for 100 random immediates and modes -> 100 outputs in order, each matching the reference model, at one per cycle.
- Assert rst asynchronously while in state TWO (between clock edges) -> out_valid=0, out_data=0 and in_ready=1 immediately. After release, the first new input emerges with no trace of the stale entries.

Source files
------------

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe: producer-side immediate/mode and consumer-side result.
// The master modport is the environment side and the slave modport is the extension unit.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extension (sign / zero / sign<<2) behind a 2-entry skid buffer.
// Define IMM_EXT_UPPER_EN to make mode 11 an upper-immediate placement; otherwise mode 11 sign-extends.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input logic           clk,
  input logic           rst,
  imm_ext_pipe_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_inReady;
  logic             r_outValid;
  logic [OUT_W-1:0] r_main;
  logic [OUT_W-1:0] r_skid;
  logic [OUT_W-1:0] w_ext;
  logic             w_msb;
  logic             w_inXfer;
  logic             w_outXfer;
  logic             w_loadMainExt;
  logic             w_loadMainSkid;
  logic             w_loadSkid;

  assign w_msb     = bus.in_data[IN_W-1];
  assign w_inXfer  = bus.in_valid && r_inReady;
  assign w_outXfer = r_outValid && bus.out_ready;

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_main;

  always_comb begin
    w_ext = {{(OUT_W-IN_W){w_msb}}, bus.in_data};
    case (bus.in_mode)
      2'b01:   w_ext = {{(OUT_W-IN_W){1'b0}}, bus.in_data};
      2'b10:   w_ext = {{(OUT_W-IN_W-2){w_msb}}, bus.in_data, 2'b00};
`ifdef IMM_EXT_UPPER_EN
      2'b11:   w_ext = {bus.in_data, {(OUT_W-IN_W){1'b0}}};
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_nextState    = r_state;
    w_loadMainExt  = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_inXfer) begin
          w_nextState   = ONE;
          w_loadMainExt = 1'b1;
        end
      end
      ONE: begin
        if (w_inXfer && w_outXfer) begin
          w_loadMainExt = 1'b1;
        end else if (w_outXfer) begin
          w_nextState = EMPTY;
        end else if (w_inXfer) begin
          w_nextState = TWO;
          w_loadSkid  = 1'b1;
        end
      end
      TWO: begin
        if (w_outXfer) begin
          w_nextState    = ONE;
          w_loadMainSkid = 1'b1;
        end
      end
      default: w_nextState = EMPTY;
    endcase
  end

  // Handshake outputs are flops decoded from the next state, so neither depends combinationally on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState != TWO);
      r_outValid <= (w_nextState != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_loadMainExt) begin
        r_main <= w_ext;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= w_ext;
      end
    end
  end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: vector table, stall/skid sequence, random stream, async reset.
// Expected results flow through a queue filled on input transfer and drained on output transfer.
module tb_imm_ext_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  typedef struct {
    logic [1:0]       mode;
    logic [IN_W-1:0]  data;
    logic [OUT_W-1:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  int   outCount;
  int   cycleCount;
  logic [OUT_W-1:0] tbExp;
  logic [OUT_W-1:0] expQ[$];
  vec_t vecs[10];

  imm_ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] refModel(input logic [1:0] m, input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] s;
    s = {{(OUT_W-IN_W){d[IN_W-1]}}, d};
    case (m)
      2'b01:   return {{(OUT_W-IN_W){1'b0}}, d};
      2'b10:   return s << 2;
`ifdef IMM_EXT_UPPER_EN
      2'b11:   return {d, {(OUT_W-IN_W){1'b0}}};
`endif
      default: return s;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [OUT_W-1:0] actual, input logic [OUT_W-1:0] required);
    nChecks++;
    if (actual !== required) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Entered just after a falling edge; holds the item until it is accepted, then returns at the next falling edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [IN_W-1:0] d, input logic [OUT_W-1:0] e);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    tbExp        = e;
    for (int k = 0; k < 100 && !got; k++) begin
      #4;
      got = bus.in_ready;
      @(negedge clk);
    end
    if (!got) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL accept_timeout: data %h never accepted, expected acceptance", d);
    end
  endtask

  // Scoreboard: samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      cycleCount++;
      if (bus.in_valid && bus.in_ready) expQ.push_back(tbExp);
      if (bus.out_valid && bus.out_ready) begin
        outCount++;
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL unexpected_output: got %h, expected no output", bus.out_data);
        end else begin
          logic [OUT_W-1:0] e;
          e = expQ.pop_front();
          if (bus.out_data !== e) begin
            nFails++;
            $display("[TB] FAIL out_data #%0d: got %h, expected %h", outCount, bus.out_data, e);
          end
        end
      end
    end
  end

  initial begin
    int oc;
    int cc;
    nChecks = 0; nFails = 0; outCount = 0; cycleCount = 0;
    tbExp = '0;
    vecs[0] = '{2'b00, 16'h8001, 32'hFFFF8001};
    vecs[1] = '{2'b01, 16'h8001, 32'h00008001};
    vecs[2] = '{2'b10, 16'hFFFF, 32'hFFFFFFFC};
    vecs[3] = '{2'b10, 16'h4000, 32'h00010000};
`ifdef IMM_EXT_UPPER_EN
    vecs[4] = '{2'b11, 16'h1234, 32'h12340000};
    vecs[5] = '{2'b11, 16'h9000, 32'h90000000};
`else
    vecs[4] = '{2'b11, 16'h1234, 32'h00001234};
    vecs[5] = '{2'b11, 16'h9000, 32'hFFFF9000};
`endif
    vecs[6] = '{2'b00, 16'h7FFF, 32'h00007FFF};
    vecs[7] = '{2'b01, 16'hFFFF, 32'h0000FFFF};
    vecs[8] = '{2'b10, 16'h8000, 32'hFFFE0000};
    vecs[9] = '{2'b00, 16'h0000, 32'h00000000};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 2'b00; bus.out_ready = 1'b0;
    #3;
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors back to back with the consumer always ready
    bus.out_ready = 1'b1;
    oc = outCount;
    foreach (vecs[i]) applyStimulus(vecs[i].mode, vecs[i].data, vecs[i].exp);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("table_output_count", 32'(outCount - oc), 32'd10);

    // Stall: two accepted, third held while the consumer is blocked
    bus.out_ready = 1'b0;
    applyStimulus(2'b01, 16'd1, 32'd1);
    applyStimulus(2'b01, 16'd2, 32'd2);
    bus.in_valid = 1'b1; bus.in_mode = 2'b01; bus.in_data = 16'd3; tbExp = 32'd3;
    for (int k = 0; k < 3; k++) begin
      checkOutput("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("stall_out_data", bus.out_data, 32'd1);
      @(negedge clk);
    end
    checkOutput("stall_pending", 32'(expQ.size()), 32'd2);
    bus.out_ready = 1'b1;
    oc = outCount;
    cc = cycleCount;
    applyStimulus(2'b01, 16'd3, 32'd3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("drain_outputs", 32'(outCount - oc), 32'd3);
    checkOutput("drain_cycles", 32'(cycleCount - cc), 32'd3);

    // Random stream at full rate
    oc = outCount;
    cc = cycleCount;
    for (int i = 0; i < 100; i++) begin
      logic [1:0]      m;
      logic [IN_W-1:0] d;
      m = 2'($urandom_range(0, 3));
      d = IN_W'($urandom);
      applyStimulus(m, d, refModel(m, d));
    end
    checkOutput("stream_cycles", 32'(cycleCount - cc), 32'd100);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("stream_outputs", 32'(outCount - oc), 32'd100);

    // Asynchronous reset while both entries are full
    bus.out_ready = 1'b0;
    applyStimulus(2'b00, 16'h8001, 32'hFFFF8001);
    applyStimulus(2'b01, 16'h0005, 32'h00000005);
    bus.in_valid = 1'b0;
    checkOutput("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("async_out_data", bus.out_data, 32'd0);
    checkOutput("async_in_ready", {31'd0, bus.in_ready}, 32'd1);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    oc = outCount;
    applyStimulus(2'b00, 16'h00AB, 32'h000000AB);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_reset_outputs", 32'(outCount - oc), 32'd1);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
